// File: rtl/sram_sp_arbiter.sv
// sram_sp_arbiter: clears a single-port SRAM after reset, then round-robin arbitrates two requesters onto it.
module sram_sp_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 65536
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ0,
  input  logic                  WE0,
  input  logic [ADDR_WIDTH-1:0] ADDR0,
  input  logic [DATA_WIDTH-1:0] WDATA0,
  output logic                  GNT0,
  output logic                  RVALID0,
  output logic [DATA_WIDTH-1:0] RDATA0,
  input  logic                  REQ1,
  input  logic                  WE1,
  input  logic [ADDR_WIDTH-1:0] ADDR1,
  input  logic [DATA_WIDTH-1:0] WDATA1,
  output logic                  GNT1,
  output logic                  RVALID1,
  output logic [DATA_WIDTH-1:0] RDATA1,
  output logic [ADDR_WIDTH-1:0] SRAM_A,
  output logic [DATA_WIDTH-1:0] SRAM_DI,
  output logic                  SRAM_ENABLE,
  output logic                  SRAM_WE,
  input  logic [DATA_WIDTH-1:0] SRAM_DO,
  output logic                  INIT_DONE
);
  typedef enum logic {INIT, RUN} state_e;
  state_e                state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  ptr_q;
  logic [1:0]            tag_q;
  logic                  run;
  always_comb begin
    run         = state_q == RUN;
    GNT0        = run & REQ0 & (~REQ1 | ~ptr_q);
    GNT1        = run & REQ1 & (~REQ0 | ptr_q);
    SRAM_ENABLE = ~run | GNT0 | GNT1;
    SRAM_WE     = run ? (GNT0 ? WE0 : GNT1 & WE1) : 1'b1;
    SRAM_A      = run ? (GNT1 ? ADDR1 : ADDR0) : cnt_q;
    SRAM_DI     = run ? (GNT1 ? WDATA1 : WDATA0) : '0;
    RVALID0     = tag_q[1] & ~tag_q[0];
    RVALID1     = tag_q[1] & tag_q[0];
    RDATA0      = SRAM_DO;
    RDATA1      = SRAM_DO;
  end
  // tag_q = {read response pending, owner}; the SRAM returns data one cycle after the access
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= INIT;
      cnt_q     <= '0;
      ptr_q     <= 1'b0;
      tag_q     <= 2'b00;
      INIT_DONE <= 1'b0;
    end else if (state_q == INIT) begin
      cnt_q <= cnt_q + ADDR_WIDTH'(1);
      tag_q <= 2'b00;
      if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
        state_q   <= RUN;
        cnt_q     <= '0;
        INIT_DONE <= 1'b1;
      end
    end else begin
      if (GNT0 | GNT1) ptr_q <= GNT0;
      tag_q <= {(GNT0 & ~WE0) | (GNT1 & ~WE1), GNT1};
    end
  end
endmodule

// File: tb/tb_sram_sp_arbiter.sv
// tb_sram_sp_arbiter: table-driven arbiter checks with a read-response scoreboard and a behavioural SRAM.
module tb_sram_sp_arbiter;
  logic        CLK = 1'b0, RST = 1'b0;
  logic        REQ0 = 0, WE0 = 0, REQ1 = 0, WE1 = 0;
  logic [15:0] ADDR0 = 0, WDATA0 = 0, ADDR1 = 0, WDATA1 = 0;
  logic        GNT0, GNT1, RVALID0, RVALID1, SRAM_ENABLE, SRAM_WE, INIT_DONE;
  logic [15:0] RDATA0, RDATA1, SRAM_A, SRAM_DI;
  logic [15:0] SRAM_DO;
  logic [15:0] mem [16];
  logic [15:0] ref_mem [16];

  sram_sp_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .DEPTH(16)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0(REQ0), .WE0(WE0), .ADDR0(ADDR0), .WDATA0(WDATA0), .GNT0(GNT0), .RVALID0(RVALID0), .RDATA0(RDATA0),
    .REQ1(REQ1), .WE1(WE1), .ADDR1(ADDR1), .WDATA1(WDATA1), .GNT1(GNT1), .RVALID1(RVALID1), .RDATA1(RDATA1),
    .SRAM_A(SRAM_A), .SRAM_DI(SRAM_DI), .SRAM_ENABLE(SRAM_ENABLE), .SRAM_WE(SRAM_WE), .SRAM_DO(SRAM_DO),
    .INIT_DONE(INIT_DONE)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK)
    if (SRAM_ENABLE) begin
      if (SRAM_WE) mem[SRAM_A[3:0]] <= SRAM_DI;
      else SRAM_DO <= mem[SRAM_A[3:0]];
    end

  typedef struct {
    logic r0, w0; logic [15:0] a0, d0;
    logic r1, w1; logic [15:0] a1, d1;
    logic g0, g1;
  } vec_t;
  typedef struct { logic v; logic o; logic [15:0] d; } rsp_t;

  rsp_t sbq[$];
  vec_t tbl[17];
  int tests = 0, fails = 0, n_g0 = 0, n_g1 = 0;

  function automatic vec_t mk(logic r0, w0, logic [15:0] a0, d0, logic r1, w1, logic [15:0] a1, d1, logic g0, g1);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_rsp();
    rsp_t e;
    e = '{1'b0, 1'b0, 16'h0};
    if (sbq.size() > 0) e = sbq.pop_front();
    chk("rvalid0", RVALID0, e.v && !e.o);
    chk("rvalid1", RVALID1, e.v && e.o);
    if (e.v) chk(e.o ? "rdata1" : "rdata0", e.o ? RDATA1 : RDATA0, e.d);
  endtask

  task automatic run_init(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      check_rsp();
      chk("init_addr", SRAM_A, i);
      chk("init_en", SRAM_ENABLE, 1);
      chk("init_we", SRAM_WE, 1);
      chk("init_di", SRAM_DI, 0);
      chk("init_gnt0", GNT0, 0);
      chk("init_gnt1", GNT1, 0);
      chk("init_done_low", INIT_DONE, 0);
      sbq.push_back('{1'b0, 1'b0, 16'h0});
      @(posedge CLK); #1;
    end
    if (n == 16) for (int i = 0; i < 16; i++) ref_mem[i] = 16'h0;
  endtask

  task automatic apply(vec_t v);
    REQ0 = v.r0; WE0 = v.w0; ADDR0 = v.a0; WDATA0 = v.d0;
    REQ1 = v.r1; WE1 = v.w1; ADDR1 = v.a1; WDATA1 = v.d1;
    @(negedge CLK);
    check_rsp();
    chk("init_done", INIT_DONE, 1);
    chk("gnt0", GNT0, v.g0);
    chk("gnt1", GNT1, v.g1);
    chk("sram_en", SRAM_ENABLE, v.g0 | v.g1);
    chk("sram_we", SRAM_WE, v.g0 ? v.w0 : (v.g1 & v.w1));
    if (v.g0 | v.g1) chk("sram_a", SRAM_A, v.g0 ? v.a0 : v.a1);
    if ((v.g0 & v.w0) | (v.g1 & v.w1)) chk("sram_di", SRAM_DI, v.g0 ? v.d0 : v.d1);
    if (v.g0 | v.g1) begin
      if (v.g0 ? v.w0 : v.w1) begin
        sbq.push_back('{1'b0, 1'b0, 16'h0});
        ref_mem[v.g0 ? v.a0[3:0] : v.a1[3:0]] = v.g0 ? v.d0 : v.d1;
      end else
        sbq.push_back('{1'b1, v.g1, ref_mem[v.g0 ? v.a0[3:0] : v.a1[3:0]]});
    end else
      sbq.push_back('{1'b0, 1'b0, 16'h0});
    n_g0 += int'(v.g0);
    n_g1 += int'(v.g1);
    @(posedge CLK); #1;
  endtask

  initial begin
    tbl[0]  = mk(1,0,7,0,          0,0,0,0,          1,0);
    tbl[1]  = mk(1,0,5,0,          0,0,0,0,          1,0);
    tbl[2]  = mk(1,1,3,16'hBEEF,   0,0,0,0,          1,0);
    tbl[3]  = mk(0,0,0,0,          1,0,3,0,          0,1);
    tbl[4]  = mk(1,1,8,16'h1111,   1,0,3,0,          1,0);
    tbl[5]  = mk(1,1,9,16'h2222,   1,0,3,0,          0,1);
    tbl[6]  = mk(1,1,9,16'h2222,   1,0,8,0,          1,0);
    tbl[7]  = mk(1,0,9,0,          1,0,8,0,          0,1);
    tbl[8]  = mk(1,0,9,0,          1,1,10,16'h3333,  1,0);
    tbl[9]  = mk(1,0,10,0,         1,1,10,16'h3333,  0,1);
    tbl[10] = mk(1,0,10,0,         1,0,0,0,          1,0);
    tbl[11] = mk(1,0,15,0,         1,0,0,0,          0,1);
    tbl[12] = mk(0,0,0,0,          0,0,0,0,          0,0);
    tbl[13] = mk(0,0,0,0,          1,0,8,0,          0,1);
    tbl[14] = mk(1,0,3,0,          1,0,9,0,          1,0);
    tbl[15] = mk(0,0,0,0,          1,0,9,0,          0,1);
    tbl[16] = mk(0,0,0,0,          0,0,0,0,          0,0);

    REQ0 = 1; WE0 = 0; ADDR0 = 7;
    #1 RST = 1;
    #1;
    chk("rst_done", INIT_DONE, 0);
    chk("rst_gnt0", GNT0, 0);
    chk("rst_gnt1", GNT1, 0);
    chk("rst_rvalid0", RVALID0, 0);
    chk("rst_rvalid1", RVALID1, 0);
    chk("rst_addr", SRAM_A, 0);
    @(posedge CLK); @(posedge CLK); #1;
    RST = 0;
    run_init(16);

    for (int i = 0; i < 17; i++) begin
      if (i == 4) begin n_g0 = 0; n_g1 = 0; end
      apply(tbl[i]);
      if (i == 11) begin
        chk("rr_count0", n_g0, 4);
        chk("rr_count1", n_g1, 4);
      end
    end

    apply(mk(1,0,5,0, 0,0,0,0, 1,0));
    RST = 1;
    REQ0 = 0; REQ1 = 0;
    sbq.delete();
    #1;
    chk("midrun_rvalid0", RVALID0, 0);
    chk("midrun_rvalid1", RVALID1, 0);
    chk("midrun_done", INIT_DONE, 0);
    chk("midrun_addr", SRAM_A, 0);
    @(posedge CLK); #1;
    RST = 0;
    run_init(6);
    RST = 1;
    #1;
    chk("midinit_addr", SRAM_A, 0);
    @(posedge CLK); #1;
    RST = 0;
    run_init(16);
    apply(tbl[16]);
    apply(mk(0,0,0,0, 1,0,3,0, 0,1));
    apply(tbl[16]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
